// File: rtl/pair_dist_gen.sv
// Pair-distance generator: stores up to NUM_POINTS 3-D points and streams the exact
// squared distance of every unordered pair (a<b), one pair per cycle, to the sorter.
module pair_dist_gen #(
    parameter int NUM_POINTS = 1000,
    parameter int DIM_W = 17,
    localparam int PT_W = $clog2(NUM_POINTS),
    localparam int DIST_W = (DIM_W + 1) * 2 + 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pt_wr_en,
    input  logic [PT_W-1:0]     pt_wr_addr,
    input  logic [DIM_W-1:0]    pt_x,
    input  logic [DIM_W-1:0]    pt_y,
    input  logic [DIM_W-1:0]    pt_z,
    input  logic [PT_W:0]       num_pts,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [DIST_W-1:0]   approx_dist,
    output logic [PT_W-1:0]     pointa_out,
    output logic [PT_W-1:0]     pointb_out,
    output logic                dist_vld
);

    localparam int SQ_W = 2 * DIM_W;
    localparam logic [PT_W:0] N_MAX = (PT_W + 1)'(NUM_POINTS);
    localparam logic [PT_W:0] ONE = (PT_W + 1)'(1);
    localparam logic [PT_W:0] TWO = (PT_W + 1)'(2);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    function automatic logic [DIM_W-1:0] abs_diff(input logic [DIM_W-1:0] p,
                                                  input logic [DIM_W-1:0] q);
        logic signed [DIM_W:0] d;
        logic [DIM_W:0] neg_d;
        d = $signed({1'b0, p}) - $signed({1'b0, q});
        neg_d = -d;
        return d[DIM_W] ? neg_d[DIM_W-1:0] : d[DIM_W-1:0];
    endfunction

    function automatic logic [SQ_W-1:0] square(input logic [DIM_W-1:0] v);
        return SQ_W'(v) * SQ_W'(v);
    endfunction

    logic [DIM_W-1:0] mem_x [NUM_POINTS];
    logic [DIM_W-1:0] mem_y [NUM_POINTS];
    logic [DIM_W-1:0] mem_z [NUM_POINTS];

    state_t          state_q;
    logic            busy_q, done_q;
    logic [PT_W-1:0] a_q, b_q;
    logic [PT_W:0]   n_q;

    logic            wr_ok, issue, last_b, last_pair;
    logic [PT_W:0]   n_clamp;

    always_comb begin
        wr_ok     = pt_wr_en && (state_q == IDLE) && !start && ({1'b0, pt_wr_addr} < N_MAX);
        issue     = (state_q == ISSUE);
        n_clamp   = (num_pts > N_MAX) ? N_MAX : num_pts;
        last_b    = ({1'b0, b_q} == n_q - ONE);
        last_pair = last_b && ({1'b0, a_q} == n_q - TWO);
    end

    // RAM contents survive reset; writes only land while idle.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_x[pt_wr_addr] <= pt_x;
            mem_y[pt_wr_addr] <= pt_y;
            mem_z[pt_wr_addr] <= pt_z;
        end
    end

    logic vld_p1_q, vld_p2_q, vld_p3_q;

    always_ff @(posedge clk) begin
        done_q <= 1'b0;
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    n_q <= n_clamp;
                    a_q <= '0;
                    b_q <= PT_W'(1);
                    if (n_clamp >= TWO) begin
                        state_q <= ISSUE;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= FIN;
                    end
                end
                ISSUE: begin
                    if (last_pair) begin
                        state_q <= DRAIN;
                    end else if (last_b) begin
                        a_q <= a_q + PT_W'(1);
                        b_q <= a_q + PT_W'(2);
                    end else begin
                        b_q <= b_q + PT_W'(1);
                    end
                end
                // Leave once only the final stage still holds data, so done lands right after the last tuple.
                DRAIN: if (!vld_p1_q && !vld_p2_q) begin
                    state_q <= FIN;
                    busy_q  <= 1'b0;
                end
                FIN: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stage 1: registered RAM read of both endpoints
    logic [DIM_W-1:0] xa_p1_q, ya_p1_q, za_p1_q, xb_p1_q, yb_p1_q, zb_p1_q;
    logic [PT_W-1:0]  a_p1_q, b_p1_q;

    always_ff @(posedge clk) begin
        xa_p1_q <= mem_x[a_q];
        ya_p1_q <= mem_y[a_q];
        za_p1_q <= mem_z[a_q];
        xb_p1_q <= mem_x[b_q];
        yb_p1_q <= mem_y[b_q];
        zb_p1_q <= mem_z[b_q];
        a_p1_q  <= a_q;
        b_p1_q  <= b_q;
    end

    // Stage 2: absolute coordinate differences
    logic [DIM_W-1:0] adx_p2_d, ady_p2_d, adz_p2_d;
    logic [DIM_W-1:0] adx_p2_q, ady_p2_q, adz_p2_q;
    logic [PT_W-1:0]  a_p2_q, b_p2_q;

    always_comb begin
        adx_p2_d = abs_diff(xa_p1_q, xb_p1_q);
        ady_p2_d = abs_diff(ya_p1_q, yb_p1_q);
        adz_p2_d = abs_diff(za_p1_q, zb_p1_q);
    end

    always_ff @(posedge clk) begin
        adx_p2_q <= adx_p2_d;
        ady_p2_q <= ady_p2_d;
        adz_p2_q <= adz_p2_d;
        a_p2_q   <= a_p1_q;
        b_p2_q   <= b_p1_q;
    end

    // Stage 3: per-axis squares
    logic [SQ_W-1:0] sqx_p3_d, sqy_p3_d, sqz_p3_d;
    logic [SQ_W-1:0] sqx_p3_q, sqy_p3_q, sqz_p3_q;
    logic [PT_W-1:0] a_p3_q, b_p3_q;

    always_comb begin
        sqx_p3_d = square(adx_p2_q);
        sqy_p3_d = square(ady_p2_q);
        sqz_p3_d = square(adz_p2_q);
    end

    always_ff @(posedge clk) begin
        sqx_p3_q <= sqx_p3_d;
        sqy_p3_q <= sqy_p3_d;
        sqz_p3_q <= sqz_p3_d;
        a_p3_q   <= a_p2_q;
        b_p3_q   <= b_p2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
        end else begin
            vld_p1_q <= issue;
            vld_p2_q <= vld_p1_q;
            vld_p3_q <= vld_p2_q;
        end
    end

    // Stage 4: sum onto the outputs, holding the last tuple while idle
    logic [DIST_W-1:0] dist_d, dist_q;
    logic [PT_W-1:0]   pa_d, pa_q, pb_d, pb_q;
    logic              vld_q;

    always_comb begin
        dist_d = dist_q;
        pa_d   = pa_q;
        pb_d   = pb_q;
        if (vld_p3_q) begin
            dist_d = DIST_W'(sqx_p3_q) + DIST_W'(sqy_p3_q) + DIST_W'(sqz_p3_q);
            pa_d   = a_p3_q;
            pb_d   = b_p3_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dist_q <= '0;
            pa_q   <= '0;
            pb_q   <= '0;
            vld_q  <= 1'b0;
        end else begin
            dist_q <= dist_d;
            pa_q   <= pa_d;
            pb_q   <= pb_d;
            vld_q  <= vld_p3_q;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign approx_dist = dist_q;
    assign pointa_out  = pa_q;
    assign pointb_out  = pb_q;
    assign dist_vld    = vld_q;

endmodule

// File: tb/tb_pair_dist_gen.sv
// Self-checking bench for pair_dist_gen: directed tables, random point sets against a
// pair-enumeration reference model, and reset/abort sequences.
module tb_pair_dist_gen;

    localparam int NP = 1000;
    localparam int DW = 17;
    localparam int PW = $clog2(NP);
    localparam int DISTW = (DW + 1) * 2 + 2;
    localparam longint MAXC = 131071;

    logic             clk = 1'b0;
    logic             rst;
    logic             pt_wr_en;
    logic [PW-1:0]    pt_wr_addr;
    logic [DW-1:0]    pt_x, pt_y, pt_z;
    logic [PW:0]      num_pts;
    logic             start;
    logic             busy, done, dist_vld;
    logic [DISTW-1:0] approx_dist;
    logic [PW-1:0]    pointa_out, pointb_out;

    pair_dist_gen #(.NUM_POINTS(NP), .DIM_W(DW)) dut (
        .clk(clk), .rst(rst), .pt_wr_en(pt_wr_en), .pt_wr_addr(pt_wr_addr),
        .pt_x(pt_x), .pt_y(pt_y), .pt_z(pt_z), .num_pts(num_pts), .start(start),
        .busy(busy), .done(done), .approx_dist(approx_dist),
        .pointa_out(pointa_out), .pointb_out(pointb_out), .dist_vld(dist_vld)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    longint mx [NP];
    longint my [NP];
    longint mz [NP];

    typedef struct { longint d; int a; int b; } tup_t;
    tup_t   expq[$];
    longint gotq[$];

    typedef struct { longint ax, ay, az, bx, by, bz, exp_d; } pcase_t;
    pcase_t pcases[5];
    longint tri_exp[3];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sqd(input int i, input int j);
        longint dx, dy, dz;
        dx = mx[i] - mx[j];
        dy = my[i] - my[j];
        dz = mz[i] - mz[j];
        return dx * dx + dy * dy + dz * dz;
    endfunction

    task automatic write_pt(input int addr, input longint x, input longint y, input longint z);
        @(negedge clk);
        pt_wr_en   = 1'b1;
        pt_wr_addr = PW'(addr);
        pt_x = DW'(x);
        pt_y = DW'(y);
        pt_z = DW'(z);
        @(negedge clk);
        pt_wr_en = 1'b0;
        if (addr < NP) begin
            mx[addr] = x;
            my[addr] = y;
            mz[addr] = z;
        end
    endtask

    // Cycle c=1 is the first cycle after the edge that samples start.
    task automatic run(input int n, input bit disturb);
        int  ntup, k, maxc;
        bit  done_seen;
        tup_t t;
        expq.delete();
        gotq.delete();
        for (int i = 0; i < n; i++)
            for (int j = i + 1; j < n; j++) begin
                t.d = sqd(i, j); t.a = i; t.b = j;
                expq.push_back(t);
            end
        ntup = expq.size();
        @(negedge clk);
        num_pts = (PW + 1)'(n);
        start = 1'b1;
        k = 0;
        done_seen = 1'b0;
        maxc = ntup + 20;
        for (int c = 1; c <= maxc && !done_seen; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                chk("busy_after_start", longint'(busy), longint'(n >= 2));
            end
            if (disturb && c == 10) begin
                start = 1'b1;
                pt_wr_en = 1'b1;
                pt_wr_addr = PW'(3);
                pt_x = DW'(12345); pt_y = DW'(777); pt_z = DW'(99999);
            end
            if (disturb && c == 11) begin
                start = 1'b0;
                pt_wr_en = 1'b0;
            end
            if (n < 2 && !done) chk("busy_idle_run", longint'(busy), 0);
            if (dist_vld) begin
                if (k < ntup) begin
                    chk("tuple_dist", longint'(approx_dist), expq[k].d);
                    chk("tuple_a", longint'(pointa_out), longint'(expq[k].a));
                    chk("tuple_b", longint'(pointb_out), longint'(expq[k].b));
                    chk("tuple_cycle", longint'(c), longint'(5 + k));
                    gotq.push_back(longint'(approx_dist));
                end else begin
                    chk("extra_tuple", longint'(k + 1), longint'(ntup));
                end
                k++;
            end
            if (done) begin
                done_seen = 1'b1;
                chk("done_cycle", longint'(c), (n >= 2) ? longint'(5 + ntup) : 2);
                chk("busy_at_done", longint'(busy), 0);
            end
        end
        chk("tuple_count", longint'(k), longint'(ntup));
        chk("done_seen", longint'(done_seen), 1);
        @(negedge clk);
        chk("done_single", longint'(done), 0);
    endtask

    initial begin
        int k, c;
        bit quiet;

        pcases[0] = '{0, 0, 0, MAXC, MAXC, MAXC, 64'd51538821123};
        pcases[1] = '{MAXC, MAXC, MAXC, 0, 0, 0, 64'd51538821123};
        pcases[2] = '{3, 4, 0, 0, 0, 0, 25};
        pcases[3] = '{0, 0, 10, 0, 0, 7, 9};
        pcases[4] = '{MAXC, 0, 5, 0, MAXC, 5, 64'd34359214082};
        tri_exp[0] = 25; tri_exp[1] = 9; tri_exp[2] = 12;

        rst = 1'b1; pt_wr_en = 1'b0; pt_wr_addr = '0;
        pt_x = '0; pt_y = '0; pt_z = '0; num_pts = '0; start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_vld", longint'(dist_vld), 0);
        chk("rst_dist", longint'(approx_dist), 0);
        chk("rst_pa", longint'(pointa_out), 0);
        chk("rst_pb", longint'(pointb_out), 0);

        // Three-point example with known distances.
        write_pt(0, 0, 0, 0);
        write_pt(1, 3, 4, 0);
        write_pt(2, 1, 2, 2);
        run(3, 1'b0);
        for (int i = 0; i < 3; i++)
            chk("tri_dist", (i < gotq.size()) ? gotq[i] : -1, tri_exp[i]);

        // Two-point table, including maximal and swapped coordinates.
        for (int i = 0; i < 5; i++) begin
            write_pt(0, pcases[i].ax, pcases[i].ay, pcases[i].az);
            write_pt(1, pcases[i].bx, pcases[i].by, pcases[i].bz);
            run(2, 1'b0);
            chk("pair_table", (gotq.size() > 0) ? gotq[0] : -1, pcases[i].exp_d);
        end

        run(1, 1'b0);
        run(0, 1'b0);

        // Random point cloud with extremes; disturbances mid-run must not matter.
        for (int i = 0; i < 20; i++)
            write_pt(i, longint'($urandom_range(131071, 0)), longint'($urandom_range(131071, 0)),
                     longint'($urandom_range(131071, 0)));
        write_pt(5, MAXC, MAXC, MAXC);
        write_pt(6, 0, 0, 0);
        write_pt(1010, 1, 1, 1);
        run(20, 1'b1);
        run(20, 1'b0);
        run(7, 1'b0);

        // Reset after the 50th tuple aborts the run without done.
        @(negedge clk);
        num_pts = (PW + 1)'(20);
        start = 1'b1;
        k = 0;
        c = 0;
        while (k < 50 && c < 200) begin
            @(negedge clk);
            start = 1'b0;
            if (dist_vld) k++;
            c++;
        end
        chk("abort_reached_50", longint'(k), 50);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_vld", longint'(dist_vld), 0);
        chk("abort_dist", longint'(approx_dist), 0);
        chk("abort_pa", longint'(pointa_out), 0);
        chk("abort_pb", longint'(pointb_out), 0);
        chk("abort_busy", longint'(busy), 0);
        chk("abort_done", longint'(done), 0);
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || dist_vld || busy) quiet = 1'b0;
        end
        chk("abort_quiet", longint'(quiet), 1);
        run(20, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
